// File: rtl/adder_scheduler.sv
// adder_scheduler: two requesters share one bit-serial full adder under round-robin arbitration.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   req0/a0/b0   requester 0 level request and operands
//   req1/a1/b1   requester 1 level request and operands
//   gnt          registered one-hot grant (bit0 = requester 0)
//   busy         high in ADD and DONE
//   sum          last completed result, MSB is the final carry
//   done         one-cycle pulse when sum is updated
//   done_id      requester index of the result on sum
module adder_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH:0]   sum,
    output logic             done,
    output logic             done_id
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, last_q;
    logic             win1, fa_y, fa_co;
    // last_q holds the requester served most recently; the other one wins a tie
    assign win1  = req1 & (~req0 | ~last_q);
    assign fa_y  = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            sum     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req0 | req1) begin
                    state_q <= ADD;
                    a_q     <= win1 ? a1 : a0;
                    b_q     <= win1 ? b1 : b0;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    gnt     <= win1 ? 2'b10 : 2'b01;
                    busy    <= 1'b1;
                    last_q  <= win1;
                end
                ADD: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= {fa_y, acc_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    // final bit: assemble carry, this bit and the WIDTH-1 bits already shifted in
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        sum     <= {fa_co, fa_y, acc_q[WIDTH-1:1]};
                        done    <= 1'b1;
                        done_id <= gnt[1];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed stimulus against a cycle-count reference model of adder_scheduler.
module tb_adder_scheduler;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt;
    logic         busy, done, done_id;
    logic [W:0]   sum;
    int checks = 0, errors = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int m_rem = 0;
    logic m_id = 1'b0, m_last = 1'b1, m_did = 1'b0;
    logic [W:0] m_res = '0, m_sum = '0;
    int m_gcyc = 0;
    int g0_seen = 0, done_seen = 0;

    adder_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .sum(sum), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < 40);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got done=%b expected 1", nm, done);
        end
    endtask

    // Reference: an accepted job keeps the block busy for W+1 cycles, the last of which is the done cycle.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_rem = 0;
            m_sum = '0;
            m_did = 1'b0;
            m_last = 1'b1;
        end else if (m_rem == 0) begin
            if (req0 || req1) begin
                m_id = (req0 && req1) ? !m_last : req1;
                m_res = m_id ? a1 + b1 : a0 + b0;
                m_last = m_id;
                m_rem = W + 1;
                m_gcyc = cyc;
            end
        end else begin
            m_rem--;
            if (m_rem == 1) begin
                m_sum = m_res;
                m_did = m_id;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("gnt", gnt, (m_rem > 0) ? (m_id ? 2'b10 : 2'b01) : 2'b00);
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_rem == 1);
            chk("sum", sum, m_sum);
            chk("done_id", done_id, m_did);
            if (gnt[0]) g0_seen++;
            if (done) done_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1, gs, ds;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum, 5'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_id", done_id, 1'b0);
        // single requester 0: F + 1
        reset = 1'b0;
        req0 = 1'b1; a0 = 4'hF; b0 = 4'h1;
        @(negedge clk);
        chk("t1_gnt", gnt, 2'b01);
        wait_done("t1");
        chk("t1_sum", sum, 5'h10);
        chk("t1_id", done_id, 1'b0);
        chk("t1_latency", cyc - m_gcyc, W);
        req0 = 1'b0;
        @(negedge clk);
        // both held from reset: round robin 0 then 1
        reset = 1'b1;
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd4;
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd9;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_done("t2a");
        chk("t2a_sum", sum, 5'h07);
        chk("t2a_id", done_id, 1'b0);
        g1 = m_gcyc;
        wait_done("t2b");
        chk("t2b_sum", sum, 5'h12);
        chk("t2b_id", done_id, 1'b1);
        chk("t2_spacing", m_gcyc - g1, 6);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        // requester 1 alone, repeated
        gs = g0_seen;
        req1 = 1'b1; a1 = 4'hA; b1 = 4'h5;
        repeat (3) begin
            wait_done("t3");
            chk("t3_sum", sum, 5'h0F);
            chk("t3_id", done_id, 1'b1);
        end
        req1 = 1'b0;
        @(negedge clk);
        chk("t3_no_gnt0", g0_seen - gs, 0);
        // operands and req change mid-ADD
        req0 = 1'b1; a0 = 4'h7; b0 = 4'h7;
        @(negedge clk);
        a0 = 4'h0; b0 = 4'h0; req0 = 1'b0;
        wait_done("t4");
        chk("t4_sum", sum, 5'h0E);
        chk("t4_id", done_id, 1'b0);
        @(negedge clk);
        // reset during the third ADD cycle
        req0 = 1'b1; a0 = 4'h5; b0 = 4'h6;
        repeat (3) @(negedge clk);
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("t5_gnt", gnt, 2'b00);
        chk("t5_busy", busy, 1'b0);
        chk("t5_sum", sum, 5'h00);
        chk("t5_done", done, 1'b0);
        reset = 1'b0;
        ds = done_seen;
        repeat (10) @(negedge clk);
        chk("t5_no_done", done_seen - ds, 0);
        // exhaustive operand sweep through requester 0
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                req0 = 1'b1; a0 = W'(i); b0 = W'(j);
                wait_done("t6");
                chk("t6_sum", sum, i + j);
                req0 = 1'b0;
                @(negedge clk);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port req0  input  1  requester 0 level request; held until its done.
REQ-005 Port a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 Port req1  input  1  requester 1 level request.
REQ-007 Port a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 Port gnt  output  2  one-hot grant (bit0 = requester 0), registered.
REQ-009 Port busy  output  1  high while an addition is in progress (ADD or DONE state).
REQ-010 Port sum  output  WIDTH+1  last completed result; MSB is final carry.
REQ-011 Port done  output  1  one-cycle pulse: sum valid for granted requester.
REQ-012 Port done_id  output  1  requester index of the result on sum.

Function
REQ-013 Block SHALL share one single-bit full adder (A, B, Cin -> Y, Cout) between both requesters, computing one sum bit per clock, LSB first.
REQ-014 FSM states SHALL be IDLE, ADD, DONE; no other states reachable.
REQ-015 IDLE: no request -> stay IDLE, gnt=00, busy=0.
REQ-016 IDLE with any req at an edge -> that edge: choose winner, latch its a/b into shift registers, carry=0, bit counter=0, gnt set one-hot, state -> ADD.
REQ-017 Arbitration SHALL be round-robin: only one requesting -> it wins; both requesting -> the requester not served last wins.
REQ-018 Round-robin pointer SHALL update only on grant; after reset requester 0 has priority.
REQ-019 ADD: each edge adds operand LSBs plus carry, shifts result bit into sum shift register MSB-side, updates carry, shifts operands right, counter +1.
REQ-020 ADD edge with counter = WIDTH-1 SHALL write final carry into result MSB, load sum output register, state -> DONE.
REQ-021 Latency: done high exactly WIDTH+1 cycles after the accepting edge (WIDTH ADD cycles, then one DONE cycle).
REQ-022 DONE: done=1 and done_id=winner for exactly one cycle; gnt and busy stay asserted; next edge -> IDLE, gnt=00.
REQ-023 Minimum spacing between grants SHALL be WIDTH+2 cycles (DONE always returns through IDLE).
REQ-024 sum and done_id SHALL hold their values from one done until the next done.
REQ-025 Operands SHALL be sampled only at the accepting edge; changes on a/b during ADD SHALL not affect the result.
REQ-026 Requester dropping req mid-operation SHALL not abort; result still completes with done.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no queueing beyond the req level.
REQ-028 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1); the full-width sum never overflows.

Reset
REQ-029 reset high at an edge SHALL force state IDLE, gnt=00, busy=0, done=0, done_id=0, sum=0, carry=0, counter=0, pointer to requester 0 priority.
REQ-030 reset SHALL override all activity, including mid-ADD and DONE; the interrupted result is discarded, no done issued.
REQ-031 First edge with reset low SHALL behave as IDLE (a held req is granted on that edge).

Verification (WIDTH=4)
REQ-032 req0=1, a0=4'hF, b0=4'h1 -> gnt=01 next cycle, done after 5 cycles, sum=5'h10, done_id=0.
REQ-033 req0=req1=1 from reset, a0=3,b0=4, a1=9,b1=9 -> first done sum=5'h07 id 0, second done sum=5'h12 id 1, grants spaced 6 cycles.
REQ-034 Only req1 held continuously, a1=4'hA,b1=4'h5 -> repeated grants to 1, each sum=5'h0F, no grant to 0.
REQ-035 Change a0 to 0 mid-ADD after accepting a0=4'h7,b0=4'h7 -> sum=5'h0E regardless.
REQ-036 Assert reset during 3rd ADD cycle -> next cycle gnt=00, busy=0, sum=0, no done pulse.
REQ-037 Exhaustive: all 256 operand pairs via req0 -> every sum equals a0+b0, done exactly one cycle each.
